// File: rtl/project_select_pkg.sv
`default_nettype none
// ============================================================================
// Module  : project_select_pkg
// Brief   : Shared register map, FSM encoding and index helpers for the
//           project select controller.
// Revision: 1.0  initial release
// ============================================================================
package project_select_pkg;

    // Word offsets as seen on adr[3:2]
    localparam logic [1:0] SEL_OFF   = 2'd0;
    localparam logic [1:0] STAT_OFF  = 2'd1;
    localparam logic [1:0] GUARD_OFF = 2'd2;

    localparam logic [4:0] NONE_IDX = 5'h1F;

    localparam int STAT_BUSY_BIT       = 8;
    localparam int STAT_PEND_VALID_BIT = 9;
    localparam int STAT_LA_BIT         = 10;
    localparam int STAT_PEND_LSB       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        WAIT   = 2'd2,
        ENABLE = 2'd3
    } sel_state_t;

    // Any index past the last project collapses onto the single NONE code
    function automatic logic [4:0] norm_idx(input logic [4:0] raw, input int unsigned n);
        return ({27'd0, raw} >= n) ? NONE_IDX : raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/project_select_guard_timer.sv
`default_nettype none
// ============================================================================
// Module  : project_select_guard_timer
// Brief   : Loadable down-counter timing the dark interval between projects.
// Revision: 1.0  initial release
// ============================================================================
module project_select_guard_timer #(
    parameter int GUARD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [GUARD_W-1:0] load_val,
    input  logic               dec,
    output logic [GUARD_W-1:0] count,
    output logic               done
);

    localparam logic [GUARD_W-1:0] C_ONE = GUARD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - C_ONE;
        end
    end

    assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/project_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : project_select_ctrl
// Brief   : Wishbone-mapped break-before-make selector for wrapped projects.
//           Optional LA override enabled by PROJECT_SELECT_LA_OVERRIDE_EN.
// Revision: 1.0  initial release
// ============================================================================
module project_select_ctrl
    import project_select_pkg::*;
#(
    parameter int                 NUM_PROJECTS = 2,
    parameter logic [31:0]        BASE_ADDR    = 32'h3000_0000,
    parameter int                 GUARD_W      = 8,
    parameter logic [GUARD_W-1:0] GUARD_RST    = GUARD_W'(4)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic [7:0]              la_data_in,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic                    switch_done_o
);

    sel_state_t         state, state_nxt;
    logic [4:0]         current, current_nxt;
    logic [4:0]         pending, pending_nxt;
    logic               pending_valid, pending_valid_nxt;
    logic [4:0]         queued, queued_nxt;
    logic               queued_valid, queued_valid_nxt;
    logic [GUARD_W-1:0] guard;
    logic [GUARD_W-1:0] timer_count;
    logic               timer_done;

    logic [1:0]  word_off;
    logic        bus_hit, bus_wr, wb_sel_wr;
    logic [4:0]  wb_tgt, desired;
    logic        req_wr, la_flag;
    logic [4:0]  req_tgt;
    logic        fwd_valid;
    logic [4:0]  fwd_tgt;
    logic [31:0] rd_data;
    logic [4:0]  drive_idx;
    logic        drive_en;
    logic        unused_common;

    assign word_off  = wbs_adr_i[3:2];
    assign bus_hit   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o
                     & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & (word_off != 2'd3);
    assign bus_wr    = bus_hit & wbs_we_i;
    assign wb_sel_wr = bus_wr & (word_off == SEL_OFF) & wbs_sel_i[0];
    assign wb_tgt    = norm_idx(wbs_dat_i[4:0], NUM_PROJECTS);

    // Most recent requested target, whether idle, in flight or queued
    assign desired = queued_valid ? queued : (pending_valid ? pending : current);

`ifdef PROJECT_SELECT_LA_OVERRIDE_EN
    logic [4:0] la_tgt;
    logic       unused_la;
    assign la_tgt    = norm_idx(la_data_in[4:0], NUM_PROJECTS);
    assign req_wr    = la_data_in[7] & (la_tgt != desired);
    assign req_tgt   = la_tgt;
    assign la_flag   = 1'b1;
    assign unused_la = ^{wb_sel_wr, wb_tgt};
`else
    assign req_wr  = wb_sel_wr;
    assign req_tgt = wb_tgt;
    assign la_flag = 1'b0;
`endif

    assign unused_common = ^{la_data_in, wbs_dat_i, wbs_sel_i, wbs_adr_i[1:0], timer_count};

    always_comb begin
        rd_data = '0;
        case (word_off)
            SEL_OFF:   rd_data[4:0] = desired;
            STAT_OFF: begin
                rd_data[4:0]                  = current;
                rd_data[STAT_BUSY_BIT]        = (state != IDLE);
                rd_data[STAT_PEND_VALID_BIT]  = pending_valid;
                rd_data[STAT_LA_BIT]          = la_flag;
                rd_data[STAT_PEND_LSB +: 5]   = pending;
            end
            GUARD_OFF: rd_data[GUARD_W-1:0] = guard;
            default:   rd_data = '0;
        endcase
    end

    // Read data is zero outside the ack cycle so it can be OR-ed onto the bus
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            guard     <= GUARD_RST;
        end else begin
            wbs_ack_o <= bus_hit;
            wbs_dat_o <= (bus_hit && !wbs_we_i) ? rd_data : '0;
            if (bus_wr && (word_off == GUARD_OFF)) begin
                for (int b = 0; b < GUARD_W; b++) begin
                    if (wbs_sel_i[b/8]) guard[b] <= wbs_dat_i[b];
                end
            end
        end
    end

    project_select_guard_timer #(
        .GUARD_W (GUARD_W)
    ) u_guard_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .load     (state == DRAIN),
        .load_val (guard),
        .dec      (state == WAIT),
        .count    (timer_count),
        .done     (timer_done)
    );

    assign fwd_valid = req_wr | queued_valid;
    assign fwd_tgt   = req_wr ? req_tgt : queued;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= IDLE;
            current       <= NONE_IDX;
            pending       <= '0;
            pending_valid <= 1'b0;
            queued        <= '0;
            queued_valid  <= 1'b0;
        end else begin
            state         <= state_nxt;
            current       <= current_nxt;
            pending       <= pending_nxt;
            pending_valid <= pending_valid_nxt;
            queued        <= queued_nxt;
            queued_valid  <= queued_valid_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        current_nxt       = current;
        pending_nxt       = pending;
        pending_valid_nxt = pending_valid;
        queued_nxt        = queued;
        queued_valid_nxt  = queued_valid;
        case (state)
            IDLE: begin
                if (req_wr && (req_tgt != current)) begin
                    pending_nxt       = req_tgt;
                    pending_valid_nxt = 1'b1;
                    state_nxt         = DRAIN;
                end
            end
            DRAIN, WAIT: begin
                if (req_wr) begin
                    queued_nxt       = req_tgt;
                    queued_valid_nxt = 1'b1;
                end
                if (state == DRAIN)  state_nxt = WAIT;
                else if (timer_done) state_nxt = ENABLE;
            end
            ENABLE: begin
                // A request that arrived mid-switch chains straight into a new drain
                current_nxt      = pending;
                queued_valid_nxt = 1'b0;
                if (fwd_valid && (fwd_tgt != pending)) begin
                    pending_nxt = fwd_tgt;
                    state_nxt   = DRAIN;
                end else begin
                    pending_valid_nxt = 1'b0;
                    state_nxt         = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drive_en      = (state == IDLE) || (state == ENABLE);
    assign drive_idx     = (state == ENABLE) ? pending : current;
    assign switch_done_o = (state == ENABLE);

    for (genvar i = 0; i < NUM_PROJECTS; i++) begin : g_active
        assign active_o[i] = drive_en && (drive_idx == 5'(i));
    end

endmodule
`default_nettype wire

// File: tb/tb_project_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_project_select_ctrl
// Brief   : Scoreboard bench for project_select_ctrl (default build).
// Revision: 1.0  initial release
// ============================================================================
module tb_project_select_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic [7:0]  la = 8'h00;
    logic        ack, done;
    logic [31:0] dat_o;
    logic [1:0]  active;

    always #5 clk = ~clk;

    project_select_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_dat_i     (dat_i),
        .wbs_adr_i     (adr),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_o),
        .la_data_in    (la),
        .active_o      (active),
        .switch_done_o (done)
    );

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_cmp = 0, n_bad = 0;
    int         onehot_viol = 0, ack_twice_viol = 0;
    logic       prev_ack = 1'b0;
    logic [1:0] prev_act = 2'b00;
    logic       trace_en = 1'b0;
    logic [1:0] trace[$];
    int         done_cnt = 0;
    logic [1:0] exp_trace [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ack and watches bus/enable invariants
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_read) check("rd_data", dat_o, mon_e.data);
                end
            end
            if (prev_ack && ack) ack_twice_viol++;
            if ($countones(active) > 1) onehot_viol++;
            if ((prev_act != 2'b00) && (active != 2'b00) && (prev_act != active)) onehot_viol++;
            if (trace_en) begin
                if ((trace.size() == 0) || (trace[trace.size()-1] != active)) trace.push_back(active);
                if (done) done_cnt++;
            end
        end
        prev_ack = ack;
        prev_act = active;
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd);
        exp_t e;
        bit   got;
        e.is_read = !w;
        e.data    = exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        wb_xfer(1'b1, BASE + off, d, s, 32'd0);
    endtask

    task automatic wb_rd(input logic [31:0] off, input logic [31:0] exp_rd);
        wb_xfer(1'b0, BASE + off, 32'd0, 4'hF, exp_rd);
    endtask

    task automatic wb_noack(input logic [31:0] a, input string tag);
        int bad = 0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if ((ack !== 1'b0) || (dat_o !== 32'd0)) bad++;
        end
        stb = 1'b0; cyc = 1'b0;
        check(tag, 32'(bad), 32'd0);
    endtask

    // Called one cycle after the SELECT write edge: expects `dark` dark cycles then ENABLE
    task automatic check_switch(input int dark, input logic [1:0] exp_act, input string tag);
        int dark_bad = 0;
        for (int k = 0; k < dark; k++) begin
            if ((active !== 2'b00) || (done !== 1'b0)) dark_bad++;
            @(posedge clk); #1;
        end
        check({tag, "_dark"}, 32'(dark_bad), 32'd0);
        check({tag, "_active"}, 32'(active), 32'(exp_act));
        check({tag, "_done"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(active), 32'(exp_act));
    endtask

    task automatic hold_check(input int n, input logic [1:0] exp_act, input string tag);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if ((active !== exp_act) || (done !== 1'b0)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_trace[0] = 2'b01; exp_trace[1] = 2'b00; exp_trace[2] = 2'b10;
        exp_trace[3] = 2'b00; exp_trace[4] = 2'b01;

        repeat (3) @(posedge clk);
        #1;
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        wb_rd(32'h4, 32'h0000_001F);
        wb_rd(32'h8, 32'h0000_0004);

        // First select: six dark cycles with the default guard of 4
        wb_wr(32'h0, 32'd0, 4'hF);
        check_switch(6, 2'b01, "sel0");
        wb_rd(32'h4, 32'h0000_0000);

        // Retarget while waiting: the queued request chains after the first switch
        trace.delete();
        done_cnt = 0;
        trace_en = 1'b1;
        wb_wr(32'h0, 32'd1, 4'hF);
        repeat (2) @(posedge clk);
        wb_wr(32'h0, 32'd0, 4'hF);
        repeat (30) @(posedge clk);
        #1;
        trace_en = 1'b0;
        check("trace_len", 32'(trace.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("trace_val", (i < trace.size()) ? 32'(trace[i]) : 32'hDEAD, 32'(exp_trace[i]));
        end
        check("trace_done_cnt", 32'(done_cnt), 32'd2);

        // Zero guard gives exactly two dark cycles
        wb_wr(32'h8, 32'd0, 4'h1);
        wb_rd(32'h8, 32'd0);
        wb_wr(32'h0, 32'd1, 4'hF);
        check_switch(2, 2'b10, "g0");
        wb_wr(32'h0, 32'd1, 4'hF);
        hold_check(6, 2'b10, "resel_noop");
        wb_wr(32'h0, 32'd0, 4'b1110);
        hold_check(6, 2'b10, "bytesel_ignored");

        // Reset in the middle of a long wait
        wb_wr(32'h8, 32'd10, 4'h1);
        wb_wr(32'h0, 32'd0, 4'hF);
        wb_rd(32'h4, 32'h0000_0301);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wait_active", 32'(active), 32'd0);
        check("rst_wait_done", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        wb_rd(32'h4, 32'h0000_001F);
        wb_rd(32'h8, 32'h0000_0004);

        // Reset clears a live enable without waiting for a clock edge
        wb_wr(32'h0, 32'd1, 4'hF);
        check_switch(6, 2'b10, "post_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 32'(active), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Out-of-range target selects NONE through the full switch path
        wb_wr(32'h0, 32'd1, 4'hF);
        check_switch(6, 2'b10, "sel1");
        wb_wr(32'h0, 32'd9, 4'hF);
        check_switch(6, 2'b00, "none");
        wb_rd(32'h4, 32'h001F_001F);
        wb_wr(32'h4, 32'hFFFF_FFFF, 4'hF);
        wb_rd(32'h4, 32'h001F_001F);

        wb_noack(BASE + 32'hC, "miss_off_c");
        wb_noack(BASE + 32'h1_0000, "miss_base");

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("onehot_bbm", 32'(onehot_viol), 32'd0);
        check("ack_single", 32'(ack_twice_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
- Wishbone-mapped controller upstream of the wrapped user projects in user_project_wrapper.
- Drives the one-hot "active" enables that gate each wrapped project's tristated outputs; those enables are currently taken from raw la_data_in bits.
- Guarantees break-before-make switchover: the old project is deselected, a programmable guard interval elapses, then the new project is enabled.
- Raises a done pulse usable as an IRQ.

Parameters:
- NUM_PROJECTS, 2, number of wrapped projects / width of active bus (1..16)
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the 3-word register window
- GUARD_W, 8, width of guard-interval counter
- GUARD_RST, 8'd4, reset value of guard interval (cycles)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_data_in  in  8  LA override inputs, used only with the optional feature
- active_o  out  NUM_PROJECTS  one-hot or all-zero project enable
- switch_done_o  out  1  one-cycle pulse when a switchover completes

Behaviour:
- Reset is asynchronous and active-low; all flops clear immediately on assertion. Reset values:
  - active_o=0, switch_done_o=0, wbs_ack_o=0, wbs_dat_o=0
  - current=NONE, pending_valid=0, guard=GUARD_RST, state=IDLE
- Registers (word offsets from BASE_ADDR):
  - 0x0 SELECT (RW): [4:0] target index; any value >= NUM_PROJECTS means NONE.
  - 0x4 STATUS (RO): [4:0] current, [8] busy, [9] pending_valid, [20:16] pending index.
  - 0x8 GUARD (RW): [GUARD_W-1:0] guard cycles.
- Bus hit: stb&cyc&~ack with adr[31:4]==BASE_ADDR[31:4] and adr[3:2]!=3.
- Ack: single-cycle pulse, the cycle after the hit. ack is never high two consecutive cycles.
- Writes take effect at the ack edge.
- wbs_sel_i: only byte 0 honoured for SELECT; bytes 0..(GUARD_W/8) honoured for GUARD.
- Read data: wbs_dat_o carries register data only during the ack cycle, otherwise 0 (so it can be OR-combined on the shared bus).
- Miss or offset 0xC: no ack (another slave responds).
- STATUS writes are ignored but still acked.
- FSM states:
  - IDLE: active_o = onehot(current), or 0 if NONE.
    - SELECT write with target==current: no-op, no done pulse.
    - SELECT write with target!=current: store in pending, go DRAIN.
  - DRAIN: active_o=0 from the first DRAIN cycle; load counter=GUARD; go WAIT.
  - WAIT: decrement each cycle; at 0 go ENABLE.
    - GUARD=0: WAIT lasts exactly 1 cycle.
    - Any GUARD value: minimum total dark time is GUARD+2 cycles.
  - ENABLE: current<=pending, clear pending_valid, active_o=onehot(new), switch_done_o=1 for this cycle, go IDLE.
- busy = state!=IDLE.
- SELECT writes during busy overwrite pending (last write wins) and do not restart the guard. After ENABLE, if a write arrived during the switch and its target != current, start a new switchover immediately; otherwise discard it.
- Selecting NONE: follows the same DRAIN/WAIT path; ENABLE leaves active_o=0 and still pulses done.
- GUARD writes during WAIT affect only the next switchover.
- active_o has at most one bit set at any time, and is never set in the same cycle the previous bit clears.

Optional Feature:
- Macro: PROJECT_SELECT_LA_OVERRIDE_EN.
- With the macro defined:
  - la_data_in[7] high forces the override: la_data_in[4:0] is treated as an implicit SELECT write on every cycle where it differs from the current or pending target.
  - Wishbone SELECT writes are acked but ignored.
  - STATUS[10] reads 1.
- Without the macro: la_data_in is unused, STATUS[10]=0, and no override logic is synthesised.

Decomposition:
- Package project_select_pkg:
  - register offsets (SEL_OFF, STAT_OFF, GUARD_OFF)
  - state enum {IDLE, DRAIN, WAIT, ENABLE}
  - NONE index constant (5'h1F)
  - STATUS bit positions
- Sub-module project_select_guard_timer: loadable down-counter with load, done and count ports.
- Wishbone decode and the FSM stay in the top module.

Test Plan:
- Reset then read STATUS -> 0x0000_001F, active_o=0; read GUARD -> 4.
- Write SELECT=0 -> active_o stays 0 for GUARD+2=6 cycles, then active_o=2'b01 with switch_done_o pulsed once; a following STATUS read returns current=0, busy=0.
- From current=0, write SELECT=1, then write SELECT=0 while in WAIT -> active_o goes 01 -> 00 -> 10 (switch_done_o pulses) -> 00 -> 01 (switch_done_o pulses again); active_o is never 2'b11.
- GUARD=0, write SELECT=1 -> active_o dark for exactly 2 cycles; write SELECT=1 again -> no done pulse, active_o unchanged.
- Assert wb_rst_n_i low mid-WAIT -> active_o=0 asynchronously; after release, state=IDLE and current=NONE.
- Access address BASE_ADDR+0xC, then BASE_ADDR+0x1_0000 -> no ack and wbs_dat_o=0 for both; with PROJECT_SELECT_LA_OVERRIDE_EN, la_data_in=8'h81 -> active_o=2'b10 after the guard interval.
